// File: rtl/mac_dma_pkg.sv
// mac_dma_pkg: AHB encodings, fetch FSM states and beat tags shared by the MAC operand fetch master
package mac_dma_pkg;
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_RUN   = 2'd1;
  localparam state_t ST_DRAIN = 2'd2;
  localparam state_t ST_FIN   = 2'd3;
  localparam logic TAG_A = 1'b0;
  localparam logic TAG_B = 1'b1;
endpackage

// File: rtl/mac_vec_fetch.sv
// mac_vec_fetch: AHB-Lite master streaming alternating A/B operand words into the MAC strobe interface
module mac_vec_fetch
  import mac_dma_pkg::*;
#(
  parameter int LEN_W = 16
) (
  input  logic             hclk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [31:0]      src_a,
  input  logic [31:0]      src_b,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [31:0]      haddr,
  output logic [1:0]       htrans,
  output logic             hwrite,
  output logic [2:0]       hsize,
  output logic [31:0]      hwdata,
  input  logic             hready,
  input  logic             hresp,
  input  logic [31:0]      hrdata,
  output logic [31:0]      data_a,
  output logic             data_a_valid,
  output logic [31:0]      data_b,
  output logic             data_b_valid,
  output logic             clear
);
  state_t state_q, state_d;
  logic [31:0] haddr_q, haddr_d, ptr_a_q, ptr_a_d, ptr_b_q, ptr_b_d;
  logic [31:0] data_a_q, data_a_d, data_b_q, data_b_d;
  logic [1:0] htrans_q, htrans_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic tag_q, tag_d, dtag_q, dtag_d, dph_q, dph_d;
  logic error_q, error_d, clear_q, clear_d, va_q, va_d, vb_q, vb_d;
  logic derr, dok, acc;
  // ptr_*_q hold the next address to issue for each vector; tag_q names the beat in address phase
  always_comb begin
    derr = dph_q && hresp;
    dok = dph_q && hready && !hresp;
    acc = htrans_q == HTRANS_NONSEQ && hready && !derr;
    state_d = state_q;
    haddr_d = haddr_q;
    htrans_d = htrans_q;
    ptr_a_d = ptr_a_q;
    ptr_b_d = ptr_b_q;
    cnt_d = cnt_q;
    tag_d = tag_q;
    clear_d = 1'b0;
    error_d = error_q || derr;
    dph_d = acc || (dph_q && !hready);
    dtag_d = acc ? tag_q : dtag_q;
    va_d = dok && dtag_q == TAG_A;
    vb_d = dok && dtag_q == TAG_B;
    data_a_d = va_d ? hrdata : data_a_q;
    data_b_d = vb_d ? hrdata : data_b_q;
    case (state_q)
      ST_IDLE: if (start) begin
        error_d = 1'b0;
        state_d = len == '0 ? ST_FIN : ST_RUN;
        if (len != '0) begin
          haddr_d = src_a & 32'hFFFF_FFFC;
          ptr_a_d = (src_a & 32'hFFFF_FFFC) + 32'd4;
          ptr_b_d = src_b & 32'hFFFF_FFFC;
          htrans_d = HTRANS_NONSEQ;
          tag_d = TAG_A;
          cnt_d = len;
          clear_d = 1'b1;
        end
      end
      ST_RUN: if (derr) begin
        htrans_d = HTRANS_IDLE;
        state_d = hready ? ST_FIN : ST_DRAIN;
      end else if (acc) begin
        tag_d = ~tag_q;
        if (tag_q == TAG_A) begin
          haddr_d = ptr_b_q;
          ptr_b_d = ptr_b_q + 32'd4;
        end else if (cnt_q == LEN_W'(1)) begin
          htrans_d = HTRANS_IDLE;
          state_d = ST_DRAIN;
        end else begin
          haddr_d = ptr_a_q;
          ptr_a_d = ptr_a_q + 32'd4;
          cnt_d = cnt_q - LEN_W'(1);
        end
      end
      ST_DRAIN: state_d = (derr ? hready : !dph_q) ? ST_FIN : ST_DRAIN;
      default: state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge hclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      haddr_q <= '0;
      htrans_q <= HTRANS_IDLE;
      ptr_a_q <= '0;
      ptr_b_q <= '0;
      cnt_q <= '0;
      tag_q <= TAG_A;
      dtag_q <= TAG_A;
      dph_q <= 1'b0;
      error_q <= 1'b0;
      clear_q <= 1'b0;
      va_q <= 1'b0;
      vb_q <= 1'b0;
      data_a_q <= '0;
      data_b_q <= '0;
    end else begin
      state_q <= state_d;
      haddr_q <= haddr_d;
      htrans_q <= htrans_d;
      ptr_a_q <= ptr_a_d;
      ptr_b_q <= ptr_b_d;
      cnt_q <= cnt_d;
      tag_q <= tag_d;
      dtag_q <= dtag_d;
      dph_q <= dph_d;
      error_q <= error_d;
      clear_q <= clear_d;
      va_q <= va_d;
      vb_q <= vb_d;
      data_a_q <= data_a_d;
      data_b_q <= data_b_d;
    end
  end
  assign busy = state_q != ST_IDLE;
  assign done = state_q == ST_FIN;
  assign error = error_q;
  assign haddr = haddr_q;
  assign htrans = htrans_q;
  assign hwrite = 1'b0;
  assign hsize = HSIZE_WORD;
  assign hwdata = '0;
  assign data_a = data_a_q;
  assign data_a_valid = va_q;
  assign data_b = data_b_q;
  assign data_b_valid = vb_q;
  assign clear = clear_q;
endmodule

// File: tb/tb_mac_vec_fetch.sv
// tb_mac_vec_fetch: scoreboard bench with an AHB slave model (per-beat wait states and error injection)
module tb_mac_vec_fetch;
  localparam int LEN_W = 16;
  logic hclk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [31:0] src_a = '0, src_b = '0;
  logic [LEN_W-1:0] len = '0;
  logic busy, done, error, hwrite, hready, hresp, data_a_valid, data_b_valid, clear;
  logic [31:0] haddr, hwdata, hrdata, data_a, data_b;
  logic [1:0] htrans;
  logic [2:0] hsize;
  int n_tests = 0, n_fail = 0;
  int n_a = 0, n_b = 0, n_clr = 0, n_done = 0;
  int wait_b = 0, err_idx = -1, beat0 = 0;
  logic [31:0] exp_addr[$], exp_a[$], exp_b[$];
  logic dp_v, dp_err, dp_est;
  logic [31:0] dp_addr;
  int wcnt, acc_cnt;

  mac_vec_fetch #(.LEN_W(LEN_W)) dut (
    .hclk(hclk), .rst_n(rst_n), .start(start), .src_a(src_a), .src_b(src_b), .len(len),
    .busy(busy), .done(done), .error(error), .haddr(haddr), .htrans(htrans), .hwrite(hwrite),
    .hsize(hsize), .hwdata(hwdata), .hready(hready), .hresp(hresp), .hrdata(hrdata),
    .data_a(data_a), .data_a_valid(data_a_valid), .data_b(data_b), .data_b_valid(data_b_valid),
    .clear(clear)
  );

  always #5 hclk = ~hclk;

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return a == 32'h100 ? 32'h11 : a == 32'h200 ? 32'h22 : a ^ 32'hC0DE_0000;
  endfunction

  // slave: odd beats (B) get wait_b wait states, beat err_idx gets a two-cycle ERROR
  assign hready = !dp_v || (dp_err ? dp_est : wcnt == 0);
  assign hresp = dp_v && dp_err;
  assign hrdata = (dp_v && !dp_err && wcnt == 0) ? mem_f(dp_addr) : 32'hDEAD_BEEF;
  always @(posedge hclk or negedge rst_n) begin
    if (!rst_n) begin
      dp_v <= 1'b0; dp_err <= 1'b0; dp_est <= 1'b0; dp_addr <= '0; wcnt <= 0; acc_cnt <= 0;
    end else if (hready) begin
      dp_v <= htrans == 2'b10;
      if (htrans == 2'b10) begin
        dp_addr <= haddr;
        dp_err <= (acc_cnt - beat0) == err_idx;
        dp_est <= 1'b0;
        wcnt <= ((acc_cnt - beat0) % 2 == 1) ? wait_b : 0;
        acc_cnt <= acc_cnt + 1;
      end
    end else if (dp_err) dp_est <= 1'b1;
    else wcnt <= wcnt - 1;
  end

  task automatic step();
    logic [31:0] e;
    @(negedge hclk);
    if (htrans == 2'b10 && hready) begin
      n_tests++;
      if (exp_addr.size() == 0) begin
        n_fail++; $display("FAIL sb_addr: read of %h accepted, expected no read", haddr);
      end else begin
        e = exp_addr.pop_front();
        if (haddr !== e) begin n_fail++; $display("FAIL sb_addr: haddr=%h, expected %h", haddr, e); end
      end
    end
    if (data_a_valid) begin
      n_a++; n_tests++;
      if (exp_a.size() == 0) begin
        n_fail++; $display("FAIL sb_a: data_a strobe %h, expected none", data_a);
      end else begin
        e = exp_a.pop_front();
        if (data_a !== e) begin n_fail++; $display("FAIL sb_a: data_a=%h, expected %h", data_a, e); end
      end
    end
    if (data_b_valid) begin
      n_b++; n_tests++;
      if (exp_b.size() == 0) begin
        n_fail++; $display("FAIL sb_b: data_b strobe %h, expected none", data_b);
      end else begin
        e = exp_b.pop_front();
        if (data_b !== e) begin n_fail++; $display("FAIL sb_b: data_b=%h, expected %h", data_b, e); end
      end
    end
    n_clr += int'(clear);
    n_done += int'(done);
  endtask

  task automatic push(input logic [31:0] a, b, input int na, nd);
    for (int k = 0; k < na; k++) begin
      logic [31:0] ad;
      ad = ((k % 2 == 1) ? (b & 32'hFFFF_FFFC) : (a & 32'hFFFF_FFFC)) + 32'(4 * (k / 2));
      exp_addr.push_back(ad);
      if (k < nd) begin
        if (k % 2 == 1) exp_b.push_back(mem_f(ad));
        else exp_a.push_back(mem_f(ad));
      end
    end
  endtask

  task automatic cmd(input logic [31:0] a, b, input int l);
    src_a = a; src_b = b; len = LEN_W'(l); start = 1'b1; beat0 = acc_cnt;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!done && cyc < 300) begin step(); cyc++; end
  endtask

  task automatic test_queues(input string name);
    n_tests++;
    if (exp_addr.size() + exp_a.size() + exp_b.size() != 0) begin
      n_fail++;
      $display("FAIL %s_left: %0d addr %0d A %0d B expected items pending, expected 0 0 0", name, exp_addr.size(), exp_a.size(), exp_b.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) step();
    n_tests++;
    if ({htrans, haddr, busy, done, error, clear, data_a_valid, data_b_valid} !== '0) begin
      n_fail++;
      $display("FAIL reset_ctl: htrans=%b haddr=%h busy=%b done=%b error=%b clear=%b va=%b vb=%b, expected all 0", htrans, haddr, busy, done, error, clear, data_a_valid, data_b_valid);
    end
    n_tests++;
    if ({data_a, data_b} !== 64'h0) begin n_fail++; $display("FAIL reset_data: data_a=%h data_b=%h, expected 0 0", data_a, data_b); end
    n_tests++;
    if ({hwrite, hsize, hwdata} !== {1'b0, 3'b010, 32'h0}) begin
      n_fail++; $display("FAIL reset_ties: hwrite=%b hsize=%b hwdata=%h, expected 0 010 0", hwrite, hsize, hwdata);
    end
    rst_n = 1'b1;
    repeat (2) step();
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle: busy=%b, expected 0", busy); end
  endtask

  task automatic test_single();
    int c0 = n_clr;
    push(32'h100, 32'h200, 2, 2);
    cmd(32'h100, 32'h200, 1);
    n_tests++;
    if ({clear, busy, htrans, haddr} !== {1'b1, 1'b1, 2'b10, 32'h100}) begin
      n_fail++; $display("FAIL single_t1: clear=%b busy=%b htrans=%b haddr=%h, expected 1 1 10 00000100", clear, busy, htrans, haddr);
    end
    step(); step();
    n_tests++;
    if ({data_a_valid, data_a} !== {1'b1, 32'h11}) begin
      n_fail++; $display("FAIL single_t3: va=%b data_a=%h, expected 1 00000011", data_a_valid, data_a);
    end
    step();
    n_tests++;
    if ({data_b_valid, data_b, data_a_valid} !== {1'b1, 32'h22, 1'b0}) begin
      n_fail++; $display("FAIL single_t4: vb=%b data_b=%h va=%b, expected 1 00000022 0", data_b_valid, data_b, data_a_valid);
    end
    step();
    n_tests++;
    if ({done, busy, data_b_valid} !== 3'b110) begin
      n_fail++; $display("FAIL single_t5: done=%b busy=%b vb=%b, expected 1 1 0", done, busy, data_b_valid);
    end
    step();
    n_tests++;
    if ({done, busy, data_a, data_b} !== {2'b00, 32'h11, 32'h22}) begin
      n_fail++; $display("FAIL single_t6: done=%b busy=%b data_a=%h data_b=%h, expected 0 0 11 22", done, busy, data_a, data_b);
    end
    n_tests++;
    if (n_clr - c0 != 1) begin n_fail++; $display("FAIL single_clr: %0d clear pulses, expected 1", n_clr - c0); end
    test_queues("single");
  endtask

  task automatic test_waits();
    int a0 = n_a, b0 = n_b, c0 = n_clr, cyc;
    wait_b = 2;
    push(32'h1000, 32'h2000, 6, 6);
    cmd(32'h1000, 32'h2000, 3);
    wait_done(cyc);
    n_tests++;
    if (done !== 1'b1) begin n_fail++; $display("FAIL waits_done: done=%b after %0d cycles, expected 1", done, cyc); end
    step();
    n_tests++;
    if ({n_a - a0, n_b - b0, n_clr - c0} !== {32'd3, 32'd3, 32'd1}) begin
      n_fail++; $display("FAIL waits_cnt: A=%0d B=%0d clear=%0d, expected 3 3 1", n_a - a0, n_b - b0, n_clr - c0);
    end
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL waits_idle: busy=%b, expected 0", busy); end
    test_queues("waits");
    wait_b = 0;
  endtask

  task automatic test_len0();
    int c0 = n_clr;
    cmd(32'h40, 32'h80, 0);
    n_tests++;
    if ({done, busy, clear, htrans} !== {3'b110, 2'b00}) begin
      n_fail++; $display("FAIL len0_t1: done=%b busy=%b clear=%b htrans=%b, expected 1 1 0 00", done, busy, clear, htrans);
    end
    step();
    n_tests++;
    if ({done, busy, htrans} !== 4'b0) begin
      n_fail++; $display("FAIL len0_t2: done=%b busy=%b htrans=%b, expected 0 0 00", done, busy, htrans);
    end
    n_tests++;
    if (n_clr != c0) begin n_fail++; $display("FAIL len0_clr: %0d clear pulses, expected 0", n_clr - c0); end
  endtask

  task automatic test_error();
    int k = 0, d0 = n_done, cyc;
    err_idx = 3;
    push(32'h300, 32'h400, 4, 3);
    cmd(32'h300, 32'h400, 4);
    while (!(hresp && !hready) && k < 50) begin step(); k++; end
    n_tests++;
    if (!(hresp && !hready)) begin n_fail++; $display("FAIL err_first: hresp=%b hready=%b, expected 1 0", hresp, hready); end
    step();
    n_tests++;
    if ({htrans, hresp, hready} !== {2'b00, 2'b11}) begin
      n_fail++; $display("FAIL err_second: htrans=%b hresp=%b hready=%b, expected 00 1 1", htrans, hresp, hready);
    end
    step();
    n_tests++;
    if ({done, error, busy} !== 3'b111) begin
      n_fail++; $display("FAIL err_done: done=%b error=%b busy=%b, expected 1 1 1", done, error, busy);
    end
    step();
    n_tests++;
    if ({done, error, busy} !== 3'b010) begin
      n_fail++; $display("FAIL err_hold: done=%b error=%b busy=%b, expected 0 1 0", done, error, busy);
    end
    n_tests++;
    if (n_done - d0 != 1) begin n_fail++; $display("FAIL err_ndone: %0d done pulses, expected 1", n_done - d0); end
    test_queues("err");
    err_idx = -1;
    push(32'h500, 32'h600, 2, 2);
    cmd(32'h500, 32'h600, 1);
    n_tests++;
    if ({error, busy} !== 2'b01) begin n_fail++; $display("FAIL err_clear: error=%b busy=%b, expected 0 1", error, busy); end
    wait_done(cyc);
    n_tests++;
    if ({done, error} !== 2'b10) begin n_fail++; $display("FAIL err_rerun: done=%b error=%b after %0d cycles, expected 1 0", done, error, cyc); end
    step();
    test_queues("err_rerun");
  endtask

  task automatic test_wrap_ignore();
    int d0 = n_done, cyc;
    push(32'hFFFF_FFFC, 32'h800, 4, 4);
    cmd(32'hFFFF_FFFC, 32'h800, 2);
    step(); step();
    src_a = 32'h9000; src_b = 32'hA000; len = LEN_W'(5); start = 1'b1;
    step();
    start = 1'b0;
    wait_done(cyc);
    n_tests++;
    if (done !== 1'b1) begin n_fail++; $display("FAIL wrap_done: done=%b after %0d cycles, expected 1", done, cyc); end
    repeat (4) step();
    n_tests++;
    if ({busy, htrans, n_done - d0} !== {1'b0, 2'b00, 32'd1}) begin
      n_fail++; $display("FAIL wrap_ignore: busy=%b htrans=%b done pulses=%0d, expected 0 00 1", busy, htrans, n_done - d0);
    end
    test_queues("wrap");
  endtask

  task automatic test_reset_mid();
    int cyc;
    push(32'hA00, 32'hB00, 8, 8);
    cmd(32'hA00, 32'hB00, 4);
    step(); step();
    n_tests++;
    if ({data_a_valid, busy, htrans} !== {2'b11, 2'b10}) begin
      n_fail++; $display("FAIL rstmid_pre: va=%b busy=%b htrans=%b, expected 1 1 10", data_a_valid, busy, htrans);
    end
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({htrans, haddr, data_a_valid, data_b_valid, busy, clear} !== '0) begin
      n_fail++; $display("FAIL rstmid_now: htrans=%b haddr=%h va=%b vb=%b busy=%b clear=%b, expected all 0", htrans, haddr, data_a_valid, data_b_valid, busy, clear);
    end
    exp_addr.delete(); exp_a.delete(); exp_b.delete();
    step();
    rst_n = 1'b1;
    repeat (5) step();
    n_tests++;
    if ({busy, htrans, done} !== 4'b0) begin
      n_fail++; $display("FAIL rstmid_idle: busy=%b htrans=%b done=%b, expected 0 00 0", busy, htrans, done);
    end
    push(32'hC00, 32'hD00, 2, 2);
    cmd(32'hC00, 32'hD00, 1);
    wait_done(cyc);
    n_tests++;
    if (done !== 1'b1) begin n_fail++; $display("FAIL rstmid_rerun: done=%b after %0d cycles, expected 1", done, cyc); end
    step();
    test_queues("rstmid");
  endtask

  initial begin
    test_reset();
    test_single();
    test_waits();
    test_len0();
    test_error();
    test_wrap_ignore();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1);
  end
endmodule

// File: doc/mac_vec_fetch.md
# mac_vec_fetch

AHB-Lite master that streams operand vectors into the MAC datapath. Given two word-aligned base addresses and a length, it issues single-word reads alternating between vector A and vector B. Each returned word is presented to the MAC on the `data_a`/`data_b` valid-strobe interface, which is the same interface the AHB slave register bank drives. It sits on a master port of the system AHB matrix, beside the CPU, and removes the CPU from the per-operand load/store loop.

## Interface
Parameters:
- `LEN_W`, 16, width of element count

Ports:
- `hclk`  in  1  clock
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  one-cycle command strobe, sampled only in IDLE
- `src_a`  in  32  base address of vector A, word aligned; bits [1:0] are ignored
- `src_b`  in  32  base address of vector B, word aligned; bits [1:0] are ignored
- `len`  in  LEN_W  element pairs to fetch
- `busy`  out  1  command in progress
- `done`  out  1  one-cycle completion pulse
- `error`  out  1  sticky bus-error flag; cleared by the next accepted `start`
- `haddr`  out  32  AHB address
- `htrans`  out  2  AHB transfer type; only IDLE (2'b00) and NONSEQ (2'b10) are used
- `hwrite`  out  1  tied 0
- `hsize`  out  3  tied 3'b010 (word)
- `hwdata`  out  32  tied 0
- `hready`  in  1  AHB ready
- `hresp`  in  1  AHB error response
- `hrdata`  in  32  AHB read data
- `data_a`  out  32  operand A to the MAC
- `data_a_valid`  out  1  one-cycle strobe for `data_a`
- `data_b`  out  32  operand B to the MAC
- `data_b_valid`  out  1  one-cycle strobe for `data_b`
- `clear`  out  1  one-cycle accumulator clear at command start

## Operation
- States: IDLE, RUN, DRAIN, FIN.
- IDLE:
  - `start` with `len`≠0 latches the addresses and count, clears `error`, and moves to RUN.
  - `start` with `len`=0 moves to FIN with no bus traffic and no `clear`.
- RUN: issues 2·`len` NONSEQ reads in the order A0, B0, A1, B1, …
  - `haddr` and `htrans` change only when `hready`=1.
  - The A and B pointers each advance by 4 after their beat is accepted, wrapping modulo 2^32.
  - Once the last address phase is accepted, the block drives IDLE and moves to DRAIN.
- DRAIN: waits for the last data phase to complete, then moves to FIN.
- FIN: pulses `done` for one cycle and returns to IDLE.
- Data capture:
  - A data phase completes when `hready`=1 and `hresp`=0.
  - `hrdata` is registered to `data_a` or `data_b` according to the beat's tag, with the matching valid strobe.
  - `data_a`/`data_b` hold their value between strobes.
- Error handling:
  - On `hresp`=1 with `hready`=0 (first error cycle), `htrans`=IDLE is registered for the second cycle, cancelling any pending address.
  - The erroring beat produces no valid strobe.
  - `error` is set and the block moves to FIN.
- `start` while busy is ignored.
- Reset, asynchronous at any point: all outputs go to their reset values immediately and the latched command is discarded.

## Timing
- Reset values:
  - `htrans`=IDLE, `haddr`=0.
  - `busy`, `done`, `error`, `clear`, `data_a_valid`, `data_b_valid` = 0.
  - `data_a`, `data_b` = 0.
- `start` is sampled at edge T.
  - In cycle T+1: `clear`=1, `busy`=1, `htrans`=NONSEQ, `haddr`=`src_a`.
- Zero-wait throughput: one beat per cycle, with address and data phases pipelined.
  - `data_a_valid` for A0 at T+3.
  - `data_b_valid` for B0 at T+4.
  - Last `data_b_valid` at T+2+2·`len`.
- `done` is asserted in the cycle after the last valid strobe. `busy` stays high through the `done` cycle and is low in the following cycle.
- `len`=0: `done` and `busy` at T+1, no `clear`.
- Wait states stretch the schedule only; beat order and count are unchanged.
- Error: `done`=1 in the cycle after the second error cycle, with `error`=1 held.

## Structure
- Shared package `mac_dma_pkg`:
  - HTRANS encodings (IDLE, NONSEQ).
  - `HSIZE_WORD`.
  - State enumeration.
  - Beat-tag encoding (A/B).
- Single module; no sub-module is warranted. The address/data pipeline is one tag register plus a data-phase-valid flag.

## Test plan
- `len`=1, `src_a`=0x100, `src_b`=0x200, zero wait, memory returns 0x11 and 0x22 -> addresses 0x100, 0x200; `data_a`=0x11 at T+3; `data_b`=0x22 at T+4; `done` at T+5.
- `len`=3 with 2 wait states on every B beat -> six reads in order A,B,A,B,A,B at +4 strides; three strobes of each kind; exactly one `clear`.
- `len`=0 -> `done` and `busy` at T+1; `htrans` stays IDLE; no `clear`.
- Error response on B1 of `len`=4 -> `htrans`=IDLE in the second error cycle; only A0, B0, A1 strobes; `error`=1 and one `done`; the next `start` clears `error`.
- `start` pulsed mid-command, and `src_a`=0xFFFF_FFFC with `len`=2 -> the extra `start` is ignored; A addresses are 0xFFFF_FFFC then 0x0000_0000.
- `rst_n` low during RUN -> `htrans`=IDLE and strobes=0 immediately; after release the block idles until the next `start`.
